bram_port_arbiter: RTL and testbench

- Two-client request arbiter that sits directly upstream of one port of dual_port_BRAM_byte_en.
- Accepts byte-enabled read/write requests from two masters (e.g. fetch and load/store), grants one per cycle and drives the BRAM port signals.
- Steers the BRAM's 1-cycle-latency readData back to the client that issued the read, tagged with a response-valid pulse.

---
 rtl/bram_port_arbiter_pkg.sv | 27 ++
 rtl/rr_arbiter_2.sv | 51 +++++
 rtl/bram_port_arbiter.sv | 104 ++++++++++
 tb/tb_bram_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants for the BRAM port arbiter and its round-robin grant block.
package bram_port_arbiter_pkg;

  // Client indices, sized to index a 2-bit request/grant vector directly.
  localparam logic CLIENT_0 = 1'b0;
  localparam logic CLIENT_1 = 1'b1;

  // Arbitration modes.
  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Default request field widths.
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 8;

  // Byte-enable width for a given data width.
  function automatic int unsigned num_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Packed width of one request: read, write, byte enables, address and data.
  function automatic int unsigned req_width(input int unsigned data_width,
                                            input int unsigned addr_width);
    return 2 + num_bytes(data_width) + addr_width + data_width;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input arbiter: round-robin on ties, or fixed priority to client 0.
module rr_arbiter_2
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = ARB_RR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant_q, last_grant_d;

  // Pick at most one winner; nothing is granted while reset is held low.
  always_comb begin
    grant = 2'b00;
    if (reset) begin
      if (req[CLIENT_0] && req[CLIENT_1]) begin
        // On a tie, the client that was not granted last wins.
        if ((FIXED_PRIORITY == ARB_FIXED) || (last_grant_q == CLIENT_1)) begin
          grant[CLIENT_0] = 1'b1;
        end else begin
          grant[CLIENT_1] = 1'b1;
        end
      end else begin
        grant = req;
      end
    end
  end

  // Remember the last winner only on cycles that actually grant.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[CLIENT_1]) begin
      last_grant_d = CLIENT_1;
    end else if (grant[CLIENT_0]) begin
      last_grant_d = CLIENT_0;
    end
  end

  // last_grant register; reset value makes client 0 win the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant_q <= CLIENT_1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates two byte-enabled clients onto one BRAM port and steers read data back.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_BYTES      = num_bytes(DATA_WIDTH),
  parameter int unsigned FIXED_PRIORITY = ARB_RR
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  input  logic                  req_read_0,
  input  logic                  req_read_1,
  input  logic                  req_write_0,
  input  logic                  req_write_1,
  input  logic [NUM_BYTES-1:0]  req_byte_en_0,
  input  logic [NUM_BYTES-1:0]  req_byte_en_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  resp_valid_0,
  output logic                  resp_valid_1,
  output logic [DATA_WIDTH-1:0] resp_data_0,
  output logic [DATA_WIDTH-1:0] resp_data_1,
  output logic                  bram_readEnable,
  output logic                  bram_writeEnable,
  output logic [NUM_BYTES-1:0]  bram_writeByteEnable,
  output logic [ADDR_WIDTH-1:0] bram_address,
  output logic [DATA_WIDTH-1:0] bram_writeData,
  input  logic [DATA_WIDTH-1:0] bram_readData
);

  logic [1:0] eligible;
  logic [1:0] grant;
  logic       null_acc_0, null_acc_1;
  logic       rsp_pend_0_q, rsp_pend_1_q;

  assign eligible[CLIENT_0] = req_valid_0 && (req_read_0 || req_write_0);
  assign eligible[CLIENT_1] = req_valid_1 && (req_read_1 || req_write_1);

  rr_arbiter_2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_arb (
    .clock(clock),
    .reset(reset),
    .req  (eligible),
    .grant(grant)
  );

  // Requests with neither read nor write are accepted without touching the BRAM.
  assign null_acc_0 = reset && req_valid_0 && !req_read_0 && !req_write_0;
  assign null_acc_1 = reset && req_valid_1 && !req_read_1 && !req_write_1;

  assign req_ready_0 = grant[CLIENT_0] || null_acc_0;
  assign req_ready_1 = grant[CLIENT_1] || null_acc_1;

  // Drive the BRAM port from the granted client; all zero when idle.
  always_comb begin
    bram_readEnable      = 1'b0;
    bram_writeEnable     = 1'b0;
    bram_writeByteEnable = '0;
    bram_address         = '0;
    bram_writeData       = '0;
    unique case (grant)
      2'b01: begin
        bram_readEnable      = req_read_0;
        bram_writeEnable     = req_write_0;
        bram_writeByteEnable = req_byte_en_0;
        bram_address         = req_addr_0;
        bram_writeData       = req_wdata_0;
      end
      2'b10: begin
        bram_readEnable      = req_read_1;
        bram_writeEnable     = req_write_1;
        bram_writeByteEnable = req_byte_en_1;
        bram_address         = req_addr_1;
        bram_writeData       = req_wdata_1;
      end
      default: ;
    endcase
  end

  // Track which client owns the read data returning next cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_pend_0_q <= 1'b0;
      rsp_pend_1_q <= 1'b0;
    end else begin
      rsp_pend_0_q <= grant[CLIENT_0] && req_read_0;
      rsp_pend_1_q <= grant[CLIENT_1] && req_read_1;
    end
  end

  assign resp_valid_0 = rsp_pend_0_q;
  assign resp_valid_1 = rsp_pend_1_q;
  assign resp_data_0  = rsp_pend_0_q ? bram_readData : '0;
  assign resp_data_1  = rsp_pend_1_q ? bram_readData : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter, each with a BRAM model.
module tb_bram_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned NB = 4;

  logic clock = 1'b0;
  logic reset;
  logic req_valid_0, req_valid_1, req_read_0, req_read_1, req_write_0, req_write_1;
  logic [NB-1:0] req_byte_en_0, req_byte_en_1;
  logic [AW-1:0] req_addr_0, req_addr_1;
  logic [DW-1:0] req_wdata_0, req_wdata_1;

  logic          a_rdy0, a_rdy1, a_rv0, a_rv1, a_re, a_we;
  logic [DW-1:0] a_rd0, a_rd1, a_wdata, a_rdata;
  logic [NB-1:0] a_wbe;
  logic [AW-1:0] a_addr;
  logic          b_rdy0, b_rdy1, b_rv0, b_rv1, b_re, b_we;
  logic [DW-1:0] b_rd0, b_rd1, b_wdata, b_rdata;
  logic [NB-1:0] b_wbe;
  logic [AW-1:0] b_addr;

  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(NB), .FIXED_PRIORITY(0)) u_rr (
    .clock(clock), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(a_rdy0), .req_ready_1(a_rdy1),
    .req_read_0(req_read_0), .req_read_1(req_read_1),
    .req_write_0(req_write_0), .req_write_1(req_write_1),
    .req_byte_en_0(req_byte_en_0), .req_byte_en_1(req_byte_en_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .resp_valid_0(a_rv0), .resp_valid_1(a_rv1),
    .resp_data_0(a_rd0), .resp_data_1(a_rd1),
    .bram_readEnable(a_re), .bram_writeEnable(a_we), .bram_writeByteEnable(a_wbe),
    .bram_address(a_addr), .bram_writeData(a_wdata), .bram_readData(a_rdata)
  );

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(NB), .FIXED_PRIORITY(1)) u_fx (
    .clock(clock), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(b_rdy0), .req_ready_1(b_rdy1),
    .req_read_0(req_read_0), .req_read_1(req_read_1),
    .req_write_0(req_write_0), .req_write_1(req_write_1),
    .req_byte_en_0(req_byte_en_0), .req_byte_en_1(req_byte_en_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .resp_valid_0(b_rv0), .resp_valid_1(b_rv1),
    .resp_data_0(b_rd0), .resp_data_1(b_rd1),
    .bram_readEnable(b_re), .bram_writeEnable(b_we), .bram_writeByteEnable(b_wbe),
    .bram_address(b_addr), .bram_writeData(b_wdata), .bram_readData(b_rdata)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    a_rdata = '0;
    b_rdata = '0;
  end

  // Write-first BRAM models with one cycle of read latency.
  always @(posedge clock) begin
    if (a_we) mem_a[a_addr] <= merge(mem_a[a_addr], a_wdata, a_wbe);
    if (a_re) a_rdata <= a_we ? merge(mem_a[a_addr], a_wdata, a_wbe) : mem_a[a_addr];
    if (b_we) mem_b[b_addr] <= merge(mem_b[b_addr], b_wdata, b_wbe);
    if (b_re) b_rdata <= b_we ? merge(mem_b[b_addr], b_wdata, b_wbe) : mem_b[b_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set0(input logic v, input logic rd, input logic wr, input logic [NB-1:0] be,
                      input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    req_valid_0 = v; req_read_0 = rd; req_write_0 = wr;
    req_byte_en_0 = be; req_addr_0 = ad; req_wdata_0 = wd;
  endtask

  task automatic set1(input logic v, input logic rd, input logic wr, input logic [NB-1:0] be,
                      input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    req_valid_1 = v; req_read_1 = rd; req_write_1 = wr;
    req_byte_en_1 = be; req_addr_1 = ad; req_wdata_1 = wd;
  endtask

  initial begin
    reset = 1'b0;
    set0(0, 0, 0, '0, '0, '0);
    set1(0, 0, 0, '0, '0, '0);
    tick();
    tick();

    // Held in reset: no grants, no BRAM activity, no responses.
    set0(1, 0, 1, 4'hF, 8'd0, 32'd10);
    set1(1, 0, 1, 4'hF, 8'd1, 32'd11);
    #1;
    check_eq("rst_ready", {a_rdy1, a_rdy0}, 2'b00);
    check_eq("rst_we", a_we, 1'b0);
    check_eq("rst_resp", {a_rv1, a_rv0}, 2'b00);

    // Release with both writing: client 0 first, then client 1.
    tick();
    reset = 1'b1;
    #1;
    check_eq("w_tie_ready_rr", {a_rdy1, a_rdy0}, 2'b01);
    check_eq("w_tie_ready_fx", {b_rdy1, b_rdy0}, 2'b01);
    check_eq("w0_bram", {a_we, a_re, a_addr, a_wdata}, {1'b1, 1'b0, 8'd0, 32'd10});
    tick();
    set0(0, 0, 0, '0, '0, '0);
    #1;
    check_eq("w1_ready", {a_rdy1, a_rdy0}, 2'b10);
    check_eq("w1_bram", {a_we, a_addr, a_wdata}, {1'b1, 8'd1, 32'd11});

    // Read back on consecutive cycles.
    tick();
    set1(0, 0, 0, '0, '0, '0);
    set0(1, 1, 0, '0, 8'd0, '0);
    #1;
    check_eq("r0_ready", {a_rdy1, a_rdy0, a_re, a_we}, 4'b0110);
    tick();
    set0(0, 0, 0, '0, '0, '0);
    set1(1, 1, 0, '0, 8'd1, '0);
    #1;
    check_eq("r0_resp", {a_rv1, a_rv0, a_rd0, a_rd1}, {2'b01, 32'd10, 32'd0});
    check_eq("r1_ready", {a_rdy1, a_rdy0}, 2'b10);
    tick();
    set1(0, 0, 0, '0, '0, '0);
    #1;
    check_eq("r1_resp", {a_rv1, a_rv0, a_rd0, a_rd1}, {2'b10, 32'd0, 32'd11});

    // Continuous reads from both clients for six cycles.
    set0(1, 1, 0, '0, 8'd0, '0);
    set1(1, 1, 0, '0, 8'd1, '0);
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq($sformatf("rr_grant%0d", i), {a_rdy1, a_rdy0}, (i % 2 == 0) ? 2'b01 : 2'b10);
      check_eq($sformatf("fx_grant%0d", i), {b_rdy1, b_rdy0}, 2'b01);
      if (i > 0) begin
        check_eq($sformatf("rr_resp%0d", i), {a_rv1, a_rv0, a_rd0, a_rd1},
                 (i % 2 == 1) ? {2'b01, 32'd10, 32'd0} : {2'b10, 32'd0, 32'd11});
        check_eq($sformatf("fx_resp%0d", i), {b_rv1, b_rv0, b_rd0}, {2'b01, 32'd10});
      end
      tick();
    end
    set0(0, 0, 0, '0, '0, '0);
    set1(0, 0, 0, '0, '0, '0);
    #1;
    check_eq("rr_resp_last", {a_rv1, a_rv0, a_rd1}, {2'b10, 32'd11});
    tick();
    check_eq("idle_resp", {a_rv1, a_rv0, a_rd0, a_rd1}, {2'b00, 64'd0});

    // Read+write by client 1 over a zero word returns write-first merged data.
    set1(1, 1, 1, 4'b1100, 8'd2, 32'hCCCCBBBB);
    #1;
    check_eq("rmw_req", {a_rdy1, a_rdy0, a_re, a_we, a_wbe, a_addr},
             {2'b10, 2'b11, 4'b1100, 8'd2});
    tick();
    set1(0, 0, 0, '0, '0, '0);
    #1;
    check_eq("rmw_resp", {a_rv1, a_rv0, a_rd1, a_rd0}, {2'b10, 32'hCCCC0000, 32'd0});

    // Client 0 read lands, then a second read is cut off by reset at its edge.
    set0(1, 1, 0, '0, 8'd0, '0);
    #1;
    check_eq("pre_rst_ready", {a_rdy1, a_rdy0}, 2'b01);
    tick();
    #1;
    check_eq("pre_rst_resp", {a_rv0, a_rd0}, {1'b1, 32'd10});
    check_eq("pre_rst_ready2", {a_rdy1, a_rdy0}, 2'b01);
    reset = 1'b0;
    #1;
    check_eq("in_rst_ready", {a_rdy1, a_rdy0, a_re}, 3'b000);
    tick();
    check_eq("post_rst_resp", {a_rv1, a_rv0, b_rv0}, 3'b000);
    reset = 1'b1;
    set1(1, 1, 0, '0, 8'd1, '0);
    #1;
    check_eq("post_rst_tie", {a_rdy1, a_rdy0}, 2'b01);
    tick();
    set0(0, 0, 0, '0, '0, '0);
    set1(0, 0, 0, '0, '0, '0);
    #1;
    check_eq("post_rst_tie_resp", {a_rv1, a_rv0, a_rd0}, {2'b01, 32'd10});

    // Valid request with neither read nor write: accepted, no BRAM effect.
    tick();
    set0(1, 0, 0, 4'hF, 8'd5, 32'hDEADBEEF);
    #1;
    check_eq("null_ready", {a_rdy1, a_rdy0}, 2'b01);
    check_eq("null_bram", {a_re, a_we, a_wbe, a_addr}, {2'b00, 4'h0, 8'd0});
    tick();
    set0(0, 0, 0, '0, '0, '0);
    #1;
    check_eq("null_resp", {a_rv1, a_rv0}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
